// File: rtl/seg_capture.sv
// Display-bus reader: watches a multiplexed, active-low 7-segment bus and
// reconstructs the BCD code shown on each digit strobe once the bus has settled.
module seg_capture #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        seg_n,
  input  logic [NDIG-1:0]   dig_n,
  output logic [4*NDIG-1:0] digits,
  output logic              frame_valid,
  output logic              cap_stb,
  output logic [7:0]        cap_idx,
  output logic              err
);

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

  localparam logic [8:0] SettleW = 9'(SETTLE);

  state_e          state_q;
  logic [6:0]      seg_meta_q, seg_sync_q;
  logic [NDIG-1:0] dig_meta_q, dig_sync_q;
  logic [6:0]      lat_seg_q;
  logic [7:0]      lat_idx_q;
  logic [7:0]      cnt_q;
  logic            multi_q;
  logic [NDIG-1:0] seen_q;

  logic            any_low, multi, active;
  logic [7:0]      act_idx;
  logic [3:0]      code;
  logic            illegal;
  logic            same, restart, cap_fire;
  logic [7:0]      cnt_next;
  logic [NDIG-1:0] cap_mask, seen_base;

  // The decimal point carries no digit information.
  logic unused_dp;
  assign unused_dp = seg_n[7];

  // Two-flop synchronisers; reset to an idle (all-off, no strobe) bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      dig_meta_q <= '1;
      dig_sync_q <= '1;
    end else begin
      seg_meta_q <= seg_n[6:0];
      seg_sync_q <= seg_meta_q;
      dig_meta_q <= dig_n;
      dig_sync_q <= dig_meta_q;
    end
  end

  // Classify strobes: one low -> active index, several low -> multi.
  always_comb begin
    any_low = 1'b0;
    multi   = 1'b0;
    act_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!dig_sync_q[i]) begin
        if (any_low) multi = 1'b1;
        any_low = 1'b1;
        act_idx = 8'(i);
      end
    end
    active = any_low && !multi;
  end

  // Segment pattern (g..a, active low) to BCD; blank is 4'hA, unknown is 4'hF.
  always_comb begin
    illegal = 1'b0;
    case (seg_sync_q)
      7'h40:   code = 4'd0;
      7'h79:   code = 4'd1;
      7'h24:   code = 4'd2;
      7'h30:   code = 4'd3;
      7'h19:   code = 4'd4;
      7'h12:   code = 4'd5;
      7'h02:   code = 4'd6;
      7'h78:   code = 4'd7;
      7'h00:   code = 4'd8;
      7'h10:   code = 4'd9;
      7'h7F:   code = 4'hA;
      default: begin
        code    = 4'hF;
        illegal = 1'b1;
      end
    endcase
  end

  // Settle bookkeeping: a new latch restarts the count at 1, a matching bus
  // extends it; capture fires on the cycle the count reaches SETTLE.
  always_comb begin
    same    = active && (act_idx == lat_idx_q) && (seg_sync_q == lat_seg_q);
    restart = active && ((state_q == StWait) || !same);
    if (restart) begin
      cnt_next = 8'd1;
    end else if (cnt_q == 8'hFF) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + 8'd1;
    end
    cap_fire = (restart || ((state_q == StSettle) && same)) && ({1'b0, cnt_next} >= SettleW);
    for (int i = 0; i < NDIG; i++) begin
      cap_mask[i] = (act_idx == 8'(i));
    end
    // A completed frame is reported and cleared one cycle after it fills.
    seen_base = (&seen_q) ? '0 : seen_q;
  end

  // Capture FSM with registered outputs and frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWait;
      cnt_q       <= '0;
      lat_idx_q   <= '0;
      lat_seg_q   <= '1;
      multi_q     <= 1'b0;
      seen_q      <= '0;
      digits      <= '1;
      frame_valid <= 1'b0;
      cap_stb     <= 1'b0;
      cap_idx     <= '0;
      err         <= 1'b0;
    end else begin
      multi_q     <= multi;
      frame_valid <= &seen_q;
      cap_stb     <= cap_fire;
      err         <= (multi && !multi_q) || (cap_fire && illegal);
      seen_q      <= cap_fire ? (seen_base | cap_mask) : seen_base;
      if (cap_fire) begin
        cap_idx <= act_idx;
        for (int i = 0; i < NDIG; i++) begin
          if (cap_mask[i]) digits[4*i +: 4] <= code;
        end
      end
      if (!active) begin
        state_q <= StWait;
        cnt_q   <= '0;
      end else begin
        cnt_q     <= cnt_next;
        lat_idx_q <= act_idx;
        lat_seg_q <= seg_sync_q;
        if (cap_fire) begin
          state_q <= StHeld;
        end else if (restart) begin
          state_q <= StSettle;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus random bus traffic, all
// checked against a run-length model of the display bus.
module tb_seg_capture;

  localparam int unsigned NDIG   = 4;
  localparam int unsigned SETTLE = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        seg_n;
  logic [NDIG-1:0]   dig_n;
  logic [4*NDIG-1:0] digits;
  logic              frame_valid, cap_stb, err;
  logic [7:0]        cap_idx;

  seg_capture #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .digits      (digits),
    .frame_valid (frame_valid),
    .cap_stb     (cap_stb),
    .cap_idx     (cap_idx),
    .err         (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a capture is due when a single-strobe (strobe, pattern)
  // pair has been sampled SETTLE times in a row; outputs trail by two cycles.
  logic [6:0]      pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [NDIG-1:0] m_pdig;
  logic [6:0]      m_pseg;
  int              m_run;
  bit              m_pmulti;
  bit              d_cap [2];
  bit              d_err [2];
  int              d_idx [2];
  logic [3:0]      d_code [2];
  logic [3:0]      m_dig [NDIG];
  logic [NDIG-1:0] m_seen;
  bit              e_cap, e_err, e_fv;
  int              e_idx;
  logic [4*NDIG-1:0] e_digits;
  int              n_cap, n_err, n_fv;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int d = 0; d < 10; d++) if (p == pat_tab[d]) return {1'b0, 4'(d)};
    if (p == 7'h7F) return {1'b0, 4'hA};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_reset();
    m_pdig   = '1;
    m_pseg   = 7'h7F;
    m_run    = 0;
    m_pmulti = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_cap[i] = 1'b0; d_err[i] = 1'b0; d_idx[i] = 0; d_code[i] = 4'hF;
    end
    for (int i = 0; i < NDIG; i++) m_dig[i] = 4'hF;
    m_seen   = '0;
    e_cap    = 1'b0; e_err = 1'b0; e_fv = 1'b0; e_idx = 0;
    e_digits = '1;
  endtask

  task automatic model_step();
    logic [4:0] dec;
    int lows, k;
    bit single, multi, cap;
    e_fv = (m_seen == '1);
    if (e_fv) m_seen = '0;
    e_cap = d_cap[1];
    e_err = d_err[1];
    if (e_cap) begin
      m_dig[d_idx[1]]  = d_code[1];
      m_seen[d_idx[1]] = 1'b1;
      e_idx            = d_idx[1];
    end
    for (int i = 0; i < NDIG; i++) e_digits[4*i +: 4] = m_dig[i];
    lows   = $countones(~dig_n);
    single = (lows == 1);
    multi  = (lows > 1);
    k = 0;
    for (int i = 0; i < NDIG; i++) if (!dig_n[i]) k = i;
    if (dig_n == m_pdig && seg_n[6:0] == m_pseg) m_run++;
    else m_run = 1;
    cap = single && (m_run == int'(SETTLE));
    dec = ref_decode(seg_n[6:0]);
    d_cap[1] = d_cap[0]; d_err[1] = d_err[0]; d_idx[1] = d_idx[0]; d_code[1] = d_code[0];
    d_cap[0]  = cap;
    d_err[0]  = (multi && !m_pmulti) || (cap && dec[4]);
    d_idx[0]  = k;
    d_code[0] = dec[3:0];
    m_pdig   = dig_n;
    m_pseg   = seg_n[6:0];
    m_pmulti = multi;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (cap_stb === 1'b1) n_cap++;
    if (err === 1'b1) n_err++;
    if (frame_valid === 1'b1) n_fv++;
  endtask

  task automatic drive(input logic [NDIG-1:0] d, input logic [7:0] s);
    dig_n = d;
    seg_n = s;
  endtask

  task automatic test_reset();
    int lat;
    bit got;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(NDIG'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      checks++;
      if ({digits, frame_valid, cap_stb, err, cap_idx} !== {{(4*NDIG){1'b1}}, 3'b000, 8'h00}) begin
        errors++;
        $display("FAIL reset_hold: digits=%h fv=%b stb=%b err=%b idx=%0d, need digits all F, pulses 0, idx 0",
                 digits, frame_valid, cap_stb, err, cap_idx);
      end
    end
    rst_n = 1'b1;
    model_reset();
    n_cap = 0; n_err = 0; n_fv = 0;
    drive(4'b1110, 8'h79);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 3 * SETTLE + 10 && !got; i++) begin
      tick();
      checks++;
      if ({cap_stb, err, frame_valid, digits} !== {e_cap, e_err, e_fv, e_digits}) begin
        errors++;
        $display("FAIL reset_release cyc %0d: stb=%b err=%b fv=%b dig=%h, need stb=%b err=%b fv=%b dig=%h",
                 i, cap_stb, err, frame_valid, digits, e_cap, e_err, e_fv, e_digits);
      end
      if (cap_stb === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    checks++;
    if (lat != int'(SETTLE) + 2) begin
      errors++;
      $display("FAIL first_capture_latency: got %0d cycles, need %0d", lat, SETTLE + 2);
    end
    drive('1, 8'hFF);
    repeat (3) tick();
  endtask

  task automatic test_scan();
    logic [NDIG-1:0] sd [4];
    logic [7:0]      ss [4];
    int c0, f0, k;
    sd = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    ss = '{8'h79, 8'h24, 8'h12, 8'h10};
    c0 = n_cap;
    f0 = n_fv;
    k  = 0;
    for (int d = 0; d < 4; d++) begin
      drive(sd[d], ss[d]);
      for (int c = 0; c < 10; c++) begin
        tick();
        checks++;
        if ({cap_stb, err, frame_valid, digits} !== {e_cap, e_err, e_fv, e_digits}) begin
          errors++;
          $display("FAIL scan d%0d c%0d: stb=%b err=%b fv=%b dig=%h, need stb=%b err=%b fv=%b dig=%h",
                   d, c, cap_stb, err, frame_valid, digits, e_cap, e_err, e_fv, e_digits);
        end
        if (cap_stb === 1'b1) begin
          checks++;
          if (cap_idx !== 8'(k)) begin
            errors++;
            $display("FAIL scan_order: cap_idx=%0d, need %0d", cap_idx, k);
          end
          k++;
        end
      end
    end
    checks++;
    if (n_cap - c0 != 4) begin
      errors++;
      $display("FAIL scan_captures: got %0d, need 4", n_cap - c0);
    end
    checks++;
    if (digits !== 16'h9521) begin
      errors++;
      $display("FAIL scan_digits: got %h, need 9521", digits);
    end
    checks++;
    if (n_fv - f0 != 1) begin
      errors++;
      $display("FAIL scan_frame: got %0d frame pulses, need 1", n_fv - f0);
    end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = n_cap;
    drive(4'b1101, 8'h78);
    repeat (SETTLE - 1) tick();
    drive('1, 8'hFF);
    repeat (SETTLE + 4) tick();
    checks++;
    if (n_cap != c0) begin
      errors++;
      $display("FAIL glitch_capture: got %0d captures, need 0", n_cap - c0);
    end
    checks++;
    if (digits !== 16'h9521) begin
      errors++;
      $display("FAIL glitch_digits: got %h, need 9521", digits);
    end
  endtask

  task automatic test_patterns();
    int e0, c0;
    e0 = n_err; c0 = n_cap;
    drive(4'b1011, 8'h55);
    repeat (10) tick();
    drive('1, 8'hFF);
    repeat (4) tick();
    checks++;
    if (n_err - e0 != 1 || n_cap - c0 != 1 || digits[11:8] !== 4'hF) begin
      errors++;
      $display("FAIL illegal_pattern: errs=%0d caps=%0d d2=%h, need 1, 1, F",
               n_err - e0, n_cap - c0, digits[11:8]);
    end
    e0 = n_err;
    drive(4'b1101, 8'h7F);
    repeat (10) tick();
    drive('1, 8'hFF);
    repeat (4) tick();
    checks++;
    if (n_err != e0 || digits[7:4] !== 4'hA) begin
      errors++;
      $display("FAIL blank_pattern: errs=%0d d1=%h, need 0, A", n_err - e0, digits[7:4]);
    end
    drive(4'b0111, 8'h00);
    repeat (10) tick();
    drive('1, 8'hFF);
    repeat (4) tick();
    checks++;
    if (n_err != e0 || digits[15:12] !== 4'h8) begin
      errors++;
      $display("FAIL eight_pattern: errs=%0d d3=%h, need 0, 8", n_err - e0, digits[15:12]);
    end
    checks++;
    if (digits !== e_digits) begin
      errors++;
      $display("FAIL pattern_model: got %h, need %h", digits, e_digits);
    end
  endtask

  task automatic test_multi();
    int e0, c0, lat;
    e0 = n_err; c0 = n_cap;
    drive(4'b1100, 8'h40);
    repeat (20) tick();
    drive('1, 8'hFF);
    repeat (4) tick();
    checks++;
    if (n_err - e0 != 1 || n_cap != c0) begin
      errors++;
      $display("FAIL multi_strobe: errs=%0d caps=%0d, need 1, 0", n_err - e0, n_cap - c0);
    end
    checks++;
    if (digits !== 16'h8FA1) begin
      errors++;
      $display("FAIL multi_digits: got %h, need 8FA1", digits);
    end
    drive(4'b1011, 8'h12);
    lat = 0;
    for (int i = 1; i <= 3 * SETTLE + 10 && lat == 0; i++) begin
      tick();
      if (cap_stb === 1'b1) lat = i;
    end
    checks++;
    if (lat != int'(SETTLE) + 2 || digits !== 16'h85A1) begin
      errors++;
      $display("FAIL after_multi: latency=%0d digits=%h, need %0d, 85A1", lat, digits, SETTLE + 2);
    end
    drive('1, 8'hFF);
    repeat (3) tick();
  endtask

  task automatic test_held();
    int c0, f0;
    c0 = n_cap; f0 = n_fv;
    for (int i = 0; i < 100; i++) begin
      drive(4'b1110, {1'($urandom), 7'h40});
      tick();
    end
    checks++;
    if (n_cap - c0 != 1 || digits[3:0] !== 4'h0) begin
      errors++;
      $display("FAIL held_single_capture: caps=%0d d0=%h, need 1, 0", n_cap - c0, digits[3:0]);
    end
    checks++;
    if (n_fv - f0 != 1) begin
      errors++;
      $display("FAIL held_frame: got %0d frame pulses, need 1", n_fv - f0);
    end
    drive('1, 8'hFF);
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int c0, f0;
    drive(4'b1110, 8'h19);
    repeat (8) tick();
    drive(4'b1011, 8'h02);
    repeat (8) tick();
    c0 = n_cap;
    drive(4'b1101, 8'h30);
    repeat (SETTLE + 1) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({digits, frame_valid, cap_stb, err, cap_idx} !== {{(4*NDIG){1'b1}}, 3'b000, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: digits=%h fv=%b stb=%b err=%b idx=%0d, need all F and zeros",
               digits, frame_valid, cap_stb, err, cap_idx);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (cap_stb === 1'b1) n_cap++;
    end
    drive('1, 8'hFF);
    rst_n = 1'b1;
    model_reset();
    repeat (6) tick();
    checks++;
    if (n_cap != c0) begin
      errors++;
      $display("FAIL reset_no_capture: got %0d captures, need 0", n_cap - c0);
    end
    f0 = n_fv;
    drive(4'b1101, 8'h30);
    repeat (8) tick();
    drive(4'b0111, 8'h02);
    repeat (8) tick();
    drive('1, 8'hFF);
    repeat (3) tick();
    checks++;
    if (n_fv != f0) begin
      errors++;
      $display("FAIL reset_seen_cleared: got %0d frame pulses, need 0", n_fv - f0);
    end
    drive(4'b1110, 8'h79);
    repeat (8) tick();
    drive(4'b1011, 8'h24);
    repeat (8) tick();
    drive('1, 8'hFF);
    repeat (3) tick();
    checks++;
    if (n_fv - f0 != 1 || digits !== 16'h6231) begin
      errors++;
      $display("FAIL reset_refill: frames=%0d digits=%h, need 1, 6231", n_fv - f0, digits);
    end
  endtask

  task automatic test_random();
    logic [NDIG-1:0] d;
    logic [6:0]      s7;
    int kind, len, i0, j0;
    for (int r = 0; r < 300; r++) begin
      kind = $urandom_range(0, 9);
      d = '1;
      if (kind == 1) begin
        i0 = $urandom_range(0, NDIG - 1);
        j0 = (i0 + 1 + $urandom_range(0, NDIG - 2)) % NDIG;
        d[i0] = 1'b0;
        d[j0] = 1'b0;
      end else if (kind != 0) begin
        d[$urandom_range(0, NDIG - 1)] = 1'b0;
      end
      kind = $urandom_range(0, 9);
      if (kind < 8) s7 = pat_tab[$urandom_range(0, 9)];
      else if (kind == 8) s7 = 7'h7F;
      else s7 = 7'($urandom);
      len = $urandom_range(1, SETTLE + 4);
      for (int c = 0; c < len; c++) begin
        drive(d, {1'($urandom), s7});
        tick();
        checks++;
        if ({cap_stb, err, frame_valid, digits} !== {e_cap, e_err, e_fv, e_digits}) begin
          errors++;
          $display("FAIL random r%0d c%0d: stb=%b err=%b fv=%b dig=%h, need stb=%b err=%b fv=%b dig=%h",
                   r, c, cap_stb, err, frame_valid, digits, e_cap, e_err, e_fv, e_digits);
        end
        if (e_cap) begin
          checks++;
          if (cap_idx !== 8'(e_idx)) begin
            errors++;
            $display("FAIL random_idx r%0d: cap_idx=%0d, need %0d", r, cap_idx, e_idx);
          end
        end
      end
    end
  endtask

  initial begin
    drive('1, 8'hFF);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_scan();
    test_glitch();
    test_patterns();
    test_multi();
    test_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
